// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : mips_pkg                                              |
// | Purpose  : Shared constants for the MIPS execute path: ALU       |
// |            control codes, forward-select encodings and default   |
// |            datapath/register-index widths.                       |
// | Ports    : none (package)                                        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package mips_pkg;

   localparam int DW_DEFAULT = 32;
   localparam int RW_DEFAULT = 5;

   // ALU control codes as produced by the ALU control decoder
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   // Forward-select encodings (2'b11 behaves like FWD_IDEX)
   localparam logic [1:0] FWD_IDEX = 2'b00;
   localparam logic [1:0] FWD_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : alu_core                                              |
// | Purpose  : Combinational ALU for the execute stage.              |
// | Ports    : alu_control_i - 4-bit operation code                  |
// |            a_i, b_i      - operands                              |
// |            result_o      - operation result                      |
// |            zero_o        - result == 0                           |
// |            overflow_o    - signed overflow (add/sub only)        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module alu_core
   import mips_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic [3:0]    alu_control_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] result_o,
   output logic          zero_o,
   output logic          overflow_o
);

   logic [DW-1:0] w_sum;
   logic [DW-1:0] w_diff;
   logic          w_add_ovf;
   logic          w_sub_ovf;
   logic          w_slt;

   assign w_sum  = a_i + b_i;
   assign w_diff = a_i - b_i;

   // Add overflows when both operands share a sign the sum does not;
   // subtract overflows when operand signs differ and the difference
   // takes the sign of B.
   assign w_add_ovf = (a_i[DW-1] == b_i[DW-1]) && (w_sum[DW-1]  != a_i[DW-1]);
   assign w_sub_ovf = (a_i[DW-1] != b_i[DW-1]) && (w_diff[DW-1] != a_i[DW-1]);
   assign w_slt     = ($signed(a_i) < $signed(b_i));

   always_comb begin
      result_o   = w_sum;
      overflow_o = 1'b0;
      case (alu_control_i)
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_SUB: begin
            result_o   = w_diff;
            overflow_o = w_sub_ovf;
         end
         ALU_SLT: result_o = {{(DW-1){1'b0}}, w_slt};
         default: begin
            // ALU_ADD and every unassigned code execute as add
            result_o   = w_sum;
            overflow_o = w_add_ovf;
         end
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule : alu_core
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : ex_stage                                              |
// | Purpose  : MIPS execute stage: operand forwarding, ALU and the   |
// |            EX/MEM pipeline register with stall/flush control.    |
// | Ports    : clk, rst_n (sync, active-low), stall, flush           |
// |            in_valid, alu_control, alu_src, rs/rt_data, imm       |
// |            fwd_a, fwd_b, mem_fwd, wb_fwd - forwarding            |
// |            reg_write, mem_read, mem_write, mem_to_reg, write_reg |
// |            out_* - registered EX/MEM contents                    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module ex_stage
   import mips_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int RW = RW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [3:0]    alu_control,
   input  logic          alu_src,
   input  logic [DW-1:0] rs_data,
   input  logic [DW-1:0] rt_data,
   input  logic [DW-1:0] imm,
   input  logic [1:0]    fwd_a,
   input  logic [1:0]    fwd_b,
   input  logic [DW-1:0] mem_fwd,
   input  logic [DW-1:0] wb_fwd,
   input  logic          reg_write,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic          mem_to_reg,
   input  logic [RW-1:0] write_reg,
   output logic          out_valid,
   output logic [DW-1:0] alu_result,
   output logic          zero,
   output logic          overflow,
   output logic [DW-1:0] store_data,
   output logic          out_reg_write,
   output logic          out_mem_read,
   output logic          out_mem_write,
   output logic          out_mem_to_reg,
   output logic [RW-1:0] out_write_reg
);

   logic [DW-1:0] w_op_a;
   logic [DW-1:0] w_fwd_rt;
   logic [DW-1:0] w_op_b;
   logic [DW-1:0] w_result;
   logic          w_zero;
   logic          w_overflow;

   // Forwarding muxes; select 2'b11 falls back to the ID/EX value
   always_comb begin
      case (fwd_a)
         FWD_MEM: w_op_a = mem_fwd;
         FWD_WB:  w_op_a = wb_fwd;
         default: w_op_a = rs_data;
      endcase
      case (fwd_b)
         FWD_MEM: w_fwd_rt = mem_fwd;
         FWD_WB:  w_fwd_rt = wb_fwd;
         default: w_fwd_rt = rt_data;
      endcase
   end

   assign w_op_b = alu_src ? imm : w_fwd_rt;

   alu_core #(.DW(DW)) u_alu_core (
      .alu_control_i (alu_control),
      .a_i           (w_op_a),
      .b_i           (w_op_b),
      .result_o      (w_result),
      .zero_o        (w_zero),
      .overflow_o    (w_overflow)
   );

   // EX/MEM register state
   logic          valid_q,      valid_d;
   logic [DW-1:0] result_q,     result_d;
   logic          zero_q,       zero_d;
   logic          overflow_q,   overflow_d;
   logic [DW-1:0] store_q,      store_d;
   logic          reg_write_q,  reg_write_d;
   logic          mem_read_q,   mem_read_d;
   logic          mem_write_q,  mem_write_d;
   logic          mem_to_reg_q, mem_to_reg_d;
   logic [RW-1:0] write_reg_q,  write_reg_d;

   // Next state: flush > stall > load; a load with in_valid=0 and a
   // flush both produce an all-zero bubble.
   always_comb begin
      valid_d      = valid_q;
      result_d     = result_q;
      zero_d       = zero_q;
      overflow_d   = overflow_q;
      store_d      = store_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      write_reg_d  = write_reg_q;
      if (flush || (!stall && !in_valid)) begin
         valid_d      = 1'b0;
         result_d     = '0;
         zero_d       = 1'b0;
         overflow_d   = 1'b0;
         store_d      = '0;
         reg_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
         write_reg_d  = '0;
      end else if (!stall) begin
         valid_d      = 1'b1;
         result_d     = w_result;
         zero_d       = w_zero;
         overflow_d   = w_overflow;
         store_d      = w_fwd_rt;
         reg_write_d  = reg_write;
         mem_read_d   = mem_read;
         mem_write_d  = mem_write;
         mem_to_reg_d = mem_to_reg;
         write_reg_d  = write_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         result_q     <= '0;
         zero_q       <= 1'b0;
         overflow_q   <= 1'b0;
         store_q      <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         write_reg_q  <= '0;
      end else begin
         valid_q      <= valid_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
         overflow_q   <= overflow_d;
         store_q      <= store_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         write_reg_q  <= write_reg_d;
      end
   end

   assign out_valid      = valid_q;
   assign alu_result     = result_q;
   assign zero           = zero_q;
   assign overflow       = overflow_q;
   assign store_data     = store_q;
   assign out_reg_write  = reg_write_q;
   assign out_mem_read   = mem_read_q;
   assign out_mem_write  = mem_write_q;
   assign out_mem_to_reg = mem_to_reg_q;
   assign out_write_reg  = write_reg_q;

endmodule : ex_stage
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_ex_stage                                           |
// | Purpose  : Directed self-checking bench for ex_stage.            |
// | Ports    : none                                                  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_ex_stage;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst_n, stall, flush, in_valid, alu_src;
   logic [3:0]    alu_control;
   logic [DW-1:0] rs_data, rt_data, imm, mem_fwd, wb_fwd;
   logic [1:0]    fwd_a, fwd_b;
   logic          reg_write, mem_read, mem_write, mem_to_reg;
   logic [RW-1:0] write_reg;
   logic          out_valid, zero, overflow;
   logic [DW-1:0] alu_result, store_data;
   logic          out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
   logic [RW-1:0] out_write_reg;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_valid(in_valid), .alu_control(alu_control), .alu_src(alu_src),
      .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .write_reg(write_reg),
      .out_valid(out_valid), .alu_result(alu_result), .zero(zero),
      .overflow(overflow), .store_data(store_data),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
      .out_write_reg(out_write_reg)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [3:0] code, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
      in_valid    = 1'b1;
      alu_control = code;
      alu_src     = 1'b0;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
      rs_data     = a;
      rt_data     = b;
      imm         = 32'h0;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".valid"},  {31'b0, out_valid},      32'h0);
      chk({tag, ".result"}, alu_result,              32'h0);
      chk({tag, ".rw"},     {31'b0, out_reg_write},  32'h0);
      chk({tag, ".mw"},     {31'b0, out_mem_write},  32'h0);
      chk({tag, ".mr"},     {31'b0, out_mem_read},   32'h0);
      chk({tag, ".m2r"},    {31'b0, out_mem_to_reg}, 32'h0);
      chk({tag, ".zero"},   {31'b0, zero},           32'h0);
      chk({tag, ".ovf"},    {31'b0, overflow},       32'h0);
      chk({tag, ".store"},  store_data,              32'h0);
      chk({tag, ".wreg"},   {27'b0, out_write_reg},  32'h0);
   endtask

   initial begin
      // Reset with random inputs for two cycles
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      in_valid = 1'b1; alu_control = 4'(ALU_ADD_C()); alu_src = $urandom_range(0, 1) == 1;
      rs_data = $urandom; rt_data = $urandom; imm = $urandom;
      mem_fwd = $urandom; wb_fwd = $urandom;
      fwd_a = 2'($urandom_range(0, 3)); fwd_b = 2'($urandom_range(0, 3));
      reg_write = 1'b1; mem_read = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1;
      write_reg = 5'd17;
      tick();
      tick();
      chk_bubble("reset");
      rst_n = 1'b1;
      reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
      write_reg = 5'd0;

      // add 0x7FFFFFFF + 1 -> 0x80000000 with overflow
      set_op(4'b0010, 32'h7FFF_FFFF, 32'h1);
      tick();
      chk("add_ovf.result", alu_result, 32'h8000_0000);
      chk("add_ovf.ovf",    {31'b0, overflow}, 32'h1);
      chk("add_ovf.zero",   {31'b0, zero},     32'h0);
      chk("add_ovf.valid",  {31'b0, out_valid}, 32'h1);

      // sub 5 - 5 -> 0, zero set
      set_op(4'b0110, 32'd5, 32'd5);
      tick();
      chk("sub_zero.result", alu_result, 32'h0);
      chk("sub_zero.zero",   {31'b0, zero},     32'h1);
      chk("sub_zero.ovf",    {31'b0, overflow}, 32'h0);

      // sub 0x80000000 - 1 -> 0x7FFFFFFF with overflow
      set_op(4'b0110, 32'h8000_0000, 32'h1);
      tick();
      chk("sub_ovf.result", alu_result, 32'h7FFF_FFFF);
      chk("sub_ovf.ovf",    {31'b0, overflow}, 32'h1);

      // SLT -1 < 1 signed -> 1
      set_op(4'b0111, 32'hFFFF_FFFF, 32'h1);
      tick();
      chk("slt.result", alu_result, 32'h1);
      chk("slt.ovf",    {31'b0, overflow}, 32'h0);

      // SLT 1 < -1 -> 0, zero set
      set_op(4'b0111, 32'h1, 32'hFFFF_FFFF);
      tick();
      chk("slt_f.result", alu_result, 32'h0);
      chk("slt_f.zero",   {31'b0, zero}, 32'h1);

      // AND / OR / unassigned code
      set_op(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
      tick();
      chk("and.result", alu_result, 32'h0000_00F0);
      set_op(4'b0001, 32'h0000_F0F0, 32'h0000_0FF0);
      tick();
      chk("or.result", alu_result, 32'h0000_FFF0);
      set_op(4'b1111, 32'd3, 32'd4);
      tick();
      chk("dflt.result", alu_result, 32'd7);
      chk("dflt.ovf",    {31'b0, overflow}, 32'h0);

      // Forward A from MEM, B from imm
      set_op(4'b0010, 32'd99, 32'h0000_1234);
      fwd_a = 2'b01; mem_fwd = 32'd10; alu_src = 1'b1; imm = 32'd5;
      tick();
      chk("fwd_mem.result", alu_result, 32'd15);
      chk("fwd_mem.store",  store_data, 32'h0000_1234);

      // Forward rt from WB into store_data; imm feeds the ALU
      set_op(4'b0010, 32'd8, 32'h0000_1111);
      fwd_b = 2'b10; wb_fwd = 32'h0000_ABCD; alu_src = 1'b1; imm = 32'd4;
      mem_write = 1'b1; write_reg = 5'd7;
      tick();
      chk("fwd_wb.store",  store_data, 32'h0000_ABCD);
      chk("fwd_wb.result", alu_result, 32'd12);
      chk("fwd_wb.mw",     {31'b0, out_mem_write}, 32'h1);
      chk("fwd_wb.wreg",   {27'b0, out_write_reg}, 32'd7);
      mem_write = 1'b0;

      // Select 11 uses ID/EX values; forwarded rt feeds B when alu_src=0
      set_op(4'b0010, 32'd20, 32'd0);
      fwd_a = 2'b11; mem_fwd = 32'd999; fwd_b = 2'b01;
      tick();
      chk("fwd_11.result", alu_result, 32'd1019);

      // Load 100+1, then stall three cycles with changing inputs
      set_op(4'b0010, 32'd100, 32'd0);
      alu_src = 1'b1; imm = 32'd1; reg_write = 1'b1; write_reg = 5'd9;
      tick();
      chk("pre_stall.result", alu_result, 32'd101);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rs_data = 32'(i * 1000 + 7); write_reg = 5'(i + 20); reg_write = 1'b0;
         tick();
         chk("stall.result", alu_result, 32'd101);
         chk("stall.wreg",   {27'b0, out_write_reg}, 32'd9);
         chk("stall.rw",     {31'b0, out_reg_write}, 32'h1);
      end

      // flush with stall -> bubble
      reg_write = 1'b1;
      flush = 1'b1;
      tick();
      chk("flush.valid", {31'b0, out_valid},     32'h0);
      chk("flush.rw",    {31'b0, out_reg_write}, 32'h0);
      chk("flush.result", alu_result, 32'h0);
      flush = 1'b0; stall = 1'b0;

      // in_valid=0 bubble
      set_op(4'b0010, 32'd3, 32'd4);
      in_valid = 1'b0; reg_write = 1'b1; mem_write = 1'b1;
      tick();
      chk_bubble("bubble");

      // Reset mid-stall discards the held instruction
      in_valid = 1'b1;
      tick();
      chk("pre_rst.result", alu_result, 32'd7);
      stall = 1'b1; rst_n = 1'b0;
      tick();
      chk_bubble("rst_stall");
      rst_n = 1'b1; stall = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   function automatic logic [3:0] ALU_ADD_C();
      return 4'b0010;
   endfunction

endmodule : tb_ex_stage
`default_nettype wire
